// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the register file and its write-port arbiter.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One writeback transaction as presented to the register file.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/mips_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module mips_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        grant[IDX_W'(idx)]   = 1'b1;
        grant_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// Round-robin arbitration of writeback sources onto the register-file write port,
// plus a per-register busy scoreboard for decode-stage RAW hazard detection.
module mips_regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]    req_data,
  input  logic                         claim_valid,
  input  logic [REG_ADDR_W-1:0]        claim_addr,
  output logic                         claim_ready,
  input  logic [REG_ADDR_W-1:0]        src_addr_1,
  input  logic [REG_ADDR_W-1:0]        src_addr_2,
  output logic                         src_busy_1,
  output logic                         src_busy_2,
  output logic                         write_enable,
  output logic [REG_ADDR_W-1:0]        dst_addr,
  output logic [DATA_W-1:0]            write_data,
  output logic [NUM_REGS-1:0]          busy_mask
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant;
  wb_req_t             win;
  logic                xfer;
  logic                commit_hit;
  logic                claim_set;
  logic [NUM_REGS-1:0] busy_next;

  mips_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are suppressed while reset is held so nothing is handed off.
  assign req_ready = grant & {NUM_REQ{reset}};
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        win.data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A commit to the claimed register frees it at the same edge, so the claim may proceed.
  assign commit_hit  = write_enable && (dst_addr == claim_addr);
  assign claim_ready = reset &
                       ((claim_addr == REG_ZERO) | ~busy_mask[claim_addr] | commit_hit);
  assign claim_set   = claim_valid & claim_ready & (claim_addr != REG_ZERO);

  // Clear on commit first so a coinciding claim of the same register wins.
  always_comb begin
    busy_next = busy_mask;
    if (write_enable) busy_next[dst_addr] = 1'b0;
    if (claim_set)    busy_next[claim_addr] = 1'b1;
  end

  assign src_busy_1 = (src_addr_1 != REG_ZERO) & busy_mask[src_addr_1];
  assign src_busy_2 = (src_addr_2 != REG_ZERO) & busy_mask[src_addr_2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      dst_addr     <= '0;
      write_data   <= '0;
      busy_mask    <= '0;
      rr_ptr       <= '0;
    end else begin
      write_enable <= xfer && (win.addr != REG_ZERO);
      if (xfer) begin
        dst_addr   <= win.addr;
        write_data <= win.data;
        rr_ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      busy_mask <= busy_next;
    end
  end

endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected register-file writes, a monitor pops and compares.
module tb_mips_regfile_write_arbiter;
  import mips_pkg::*;

  localparam int unsigned NREQ = 3;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_addr;
  logic [32*NREQ-1:0]   req_data;
  logic                 claim_valid;
  logic [4:0]           claim_addr;
  logic                 claim_ready;
  logic [4:0]           src_addr_1;
  logic [4:0]           src_addr_2;
  logic                 src_busy_1;
  logic                 src_busy_2;
  logic                 write_enable;
  logic [4:0]           dst_addr;
  logic [31:0]          write_data;
  logic [31:0]          busy_mask;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [31:0] rf [32];

  mips_regfile_write_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .claim_valid  (claim_valid),
    .claim_addr   (claim_addr),
    .claim_ready  (claim_ready),
    .src_addr_1   (src_addr_1),
    .src_addr_2   (src_addr_2),
    .src_busy_1   (src_busy_1),
    .src_busy_2   (src_busy_2),
    .write_enable (write_enable),
    .dst_addr     (dst_addr),
    .write_data   (write_data),
    .busy_mask    (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in so readback after the commit edge can be checked.
  always @(posedge clk) if (write_enable) rf[dst_addr] <= write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every committed write must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && write_enable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(dst_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(dst_addr), 32'(e.addr));
        chk("wr_data", write_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  int          order [6];
  logic [4:0]  rr_addr [3];
  logic [31:0] rr_data [3];

  initial begin
    order   = '{1, 2, 0, 1, 2, 0};
    rr_addr = '{5'd2, 5'd3, 5'd4};
    rr_data = '{32'h0000_0020, 32'h0000_0030, 32'h0000_0040};

    reset = 1'b0;
    req_valid = '1;
    req_addr = '0;
    req_data = '0;
    claim_valid = 1'b1;
    claim_addr = 5'd5;
    src_addr_1 = 5'd0;
    src_addr_2 = 5'd0;

    // Reset with everything requesting
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_claim_ready", 32'(claim_ready), 32'h0);
    chk("rst_we", 32'(write_enable), 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    #13;
    chk("rst_busy_after_edges", busy_mask, 32'h0);
    chk("rst_we_after_edges", 32'(write_enable), 32'h0);
    req_valid = '0;
    claim_valid = 1'b0;
    #2;
    reset = 1'b1;
    step();

    // Single write req0 -> $1 = 3
    req_valid = 3'b001;
    set_req(0, 5'd1, 32'd3);
    push(5'd1, 32'd3);
    #1 chk("single_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("single_we_N", 32'(write_enable), 32'h1);
    step();
    chk("single_we_N1", 32'(write_enable), 32'h0);
    chk("single_rf_read", rf[1], 32'd3);

    // Round robin, pointer now at 1
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) set_req(i, rr_addr[i], rr_data[i]);
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_grant", 32'(req_ready), 32'(1) << order[k]);
      push(rr_addr[order[k]], rr_data[order[k]]);
      step();
      chk("rr_we", 32'(write_enable), 32'h1);
    end
    req_valid = '0;
    step();

    // Scoreboard: claim, reject duplicate, commit clears after N+1
    claim_valid = 1'b1;
    claim_addr = 5'd5;
    src_addr_1 = 5'd5;
    #1 chk("claim5_ready", 32'(claim_ready), 32'h1);
    chk("src5_idle", 32'(src_busy_1), 32'h0);
    step();
    chk("claim5_mask", busy_mask, 32'h0000_0020);
    chk("src5_busy", 32'(src_busy_1), 32'h1);
    chk("claim5_dup_rejected", 32'(claim_ready), 32'h0);
    step();
    claim_valid = 1'b0;
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'h55);
    push(5'd5, 32'h55);
    #1 chk("w5_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("w5_busy_after_N", 32'(src_busy_1), 32'h1);
    step();
    chk("w5_busy_after_N1", 32'(src_busy_1), 32'h0);
    chk("w5_mask_after_N1", busy_mask, 32'h0);

    // Reclaim coinciding with commit keeps the bit
    claim_valid = 1'b1;
    step();
    claim_valid = 1'b0;
    req_valid = 3'b100;
    set_req(2, 5'd5, 32'h5A);
    push(5'd5, 32'h5A);
    step();
    req_valid = '0;
    claim_valid = 1'b1;
    #1 chk("reclaim_commit_hit", 32'(claim_ready), 32'h1);
    step();
    claim_valid = 1'b0;
    chk("reclaim_mask", busy_mask, 32'h0000_0020);

    // Register $0: accepted, no write, claim never sets bit 0
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'd7);
    claim_valid = 1'b1;
    claim_addr = 5'd0;
    #1 chk("r0_grant", 32'(req_ready), 32'h1);
    chk("r0_claim_ready", 32'(claim_ready), 32'h1);
    step();
    req_valid = '0;
    claim_valid = 1'b0;
    chk("r0_no_we", 32'(write_enable), 32'h0);
    chk("r0_mask", busy_mask, 32'h0000_0020);

    // Async reset mid-operation, pointer currently at 1
    req_valid = 3'b010;
    set_req(1, 5'd6, 32'h66);
    push(5'd6, 32'h66);
    step();
    req_valid = 3'b111;
    set_req(0, 5'd9, 32'h99);
    set_req(2, 5'd10, 32'hAA);
    claim_valid = 1'b1;
    claim_addr = 5'd7;
    chk("ar_we_before", 32'(write_enable), 32'h1);
    chk("ar_mask_before", busy_mask, 32'h0000_0020);
    #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("ar_we", 32'(write_enable), 32'h0);
    chk("ar_dst", 32'(dst_addr), 32'h0);
    chk("ar_data", write_data, 32'h0);
    chk("ar_mask", busy_mask, 32'h0);
    chk("ar_req_ready", 32'(req_ready), 32'h0);
    chk("ar_claim_ready", 32'(claim_ready), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    claim_valid = 1'b0;
    #1 chk("ar_first_grant", 32'(req_ready), 32'h1);
    push(5'd9, 32'h99);
    step();
    req_valid = '0;
    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
